press_classifier: RTL and testbench

- Sits between the button debouncer and the counter/LED logic.
- Consumes the debouncer's press/release pulses and level, and measures press duration in millisecond ticks.
- Emits one-cycle event pulses: short, double, long and auto-repeat.
- Replaces the ad-hoc tick comparison in the counter stage with one classification point.

---
 rtl/press_classifier.sv | 98 +++++++++
 tb/tb_press_classifier.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/press_classifier.sv
// press_classifier: turns debounced press/release pulses into short, double, long and repeat events.
module press_classifier #(
    parameter int TICK_DIV  = 12000,
    parameter int LONG_MS   = 400,
    parameter int DOUBLE_MS = 250,
    parameter int REPEAT_MS = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pb_down,
    input  logic        pb_up,
    input  logic        pb_state,
    output logic        short_pulse,
    output logic        double_pulse,
    output logic        long_pulse,
    output logic        repeat_pulse,
    output logic [16:0] press_ms,
    output logic        busy
);
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [16:0] LONG_V    = 17'(LONG_MS);
    localparam logic [16:0] DOUBLE_V  = 17'(DOUBLE_MS);
    localparam logic [16:0] REPEAT_V  = 17'(REPEAT_MS);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD, WAIT_DOUBLE} state_t;
    state_t state, state_nx;

    logic [15:0] presc;
    logic [16:0] dur, dur_inc, win, rep;
    logic        second, ms_tick, up, accept, in_p, in_l, in_w;
    logic        long_hit, win_hit, rep_hit;
    logic        short_nx, double_nx, long_nx, repeat_nx;

    assign ms_tick  = presc == TICK_LAST;
    // a simultaneous pb_down always masks pb_up
    assign up       = pb_up & ~pb_down;
    assign in_p     = state == PRESSED;
    assign in_l     = state == LONG_HELD;
    assign in_w     = state == WAIT_DOUBLE;
    assign accept   = pb_down & (state == IDLE | in_w);
    assign dur_inc  = (ms_tick && dur != '1) ? dur + 17'd1 : dur;
    assign long_hit = ms_tick && dur_inc == LONG_V;
    assign win_hit  = ms_tick && (win + 17'd1) == DOUBLE_V;
    assign rep_hit  = REPEAT_MS != 0 && ms_tick && (rep + 17'd1) == REPEAT_V;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        state_nx = pb_down ? PRESSED : IDLE;
            PRESSED:     state_nx = up ? ((second || DOUBLE_MS == 0) ? IDLE : WAIT_DOUBLE)
                                  : pb_state ? IDLE : long_hit ? LONG_HELD : PRESSED;
            LONG_HELD:   state_nx = (up || pb_state) ? IDLE : LONG_HELD;
            WAIT_DOUBLE: state_nx = pb_down ? PRESSED : win_hit ? IDLE : WAIT_DOUBLE;
            default:     state_nx = IDLE;
        endcase
    end

    always_comb begin
        long_nx   = in_p && !up && !pb_state && long_hit;
        double_nx = in_p && up && second;
        repeat_nx = in_l && !up && !pb_state && rep_hit;
        // a second press that goes long reports the first press late
        short_nx  = (in_p && up && !second && DOUBLE_MS == 0) || (long_nx && second) || (in_w && win_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            dur          <= '0;
            win          <= '0;
            rep          <= '0;
            second       <= 1'b0;
            press_ms     <= '0;
            short_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            presc        <= (accept || ms_tick) ? '0 : presc + 16'd1;
            dur          <= accept ? '0 : (in_p || in_l) ? dur_inc : dur;
            win          <= (in_p && up) ? '0 : (in_w && ms_tick) ? win + 17'd1 : win;
            rep          <= long_nx ? '0 : (in_l && ms_tick) ? (rep_hit ? '0 : rep + 17'd1) : rep;
            second       <= (in_w && pb_down) ? !win_hit : (state == IDLE) ? 1'b0 : second;
            press_ms     <= ((in_p || in_l) && up) ? dur_inc : press_ms;
            short_pulse  <= short_nx;
            double_pulse <= double_nx;
            long_pulse   <= long_nx;
            repeat_pulse <= repeat_nx;
            busy         <= state_nx != IDLE;
        end
    end
endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed press scenarios with a pulse scoreboard checked by a monitor.
module tb_press_classifier;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        pb_down = 1'b0, pb_up = 1'b0, pb_state = 1'b1;
    logic        short_pulse, double_pulse, long_pulse, repeat_pulse, busy;
    logic [16:0] press_ms;
    int          cyc = 0, checks = 0, errors = 0;

    typedef struct {int c; logic [3:0] k;} ev_t;
    ev_t sb[$];

    localparam logic [3:0] SH = 4'b1000, DB = 4'b0100, LG = 4'b0010, RP = 4'b0001;

    press_classifier #(.TICK_DIV(4), .LONG_MS(10), .DOUBLE_MS(5), .REPEAT_MS(3)) dut (
        .clk(clk), .rst_n(rst_n), .pb_down(pb_down), .pb_up(pb_up), .pb_state(pb_state),
        .short_pulse(short_pulse), .double_pulse(double_pulse), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .press_ms(press_ms), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wire [3:0] pv = {short_pulse, double_pulse, long_pulse, repeat_pulse};

    always @(negedge clk) begin
        if (rst_n && pv != 4'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cycle %0d got %b expected none", cyc, pv);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (e.c != cyc || e.k != pv) begin
                    errors++;
                    $display("FAIL pulse got %b at cycle %0d expected %b at cycle %0d", pv, cyc, e.k, e.c);
                end
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(int c);
        while (cyc < c - 1) step();
    endtask

    task automatic press(output int c);
        pb_down = 1'b1;
        pb_state = 1'b0;
        step();
        pb_down = 1'b0;
        c = cyc;
    endtask

    task automatic release_btn();
        pb_up = 1'b1;
        pb_state = 1'b1;
        step();
        pb_up = 1'b0;
    endtask

    task automatic push(int c, logic [3:0] k);
        sb.push_back('{c, k});
    endtask

    initial begin
        int c0, c2;
        repeat (3) step();
        chk("reset_pulses", int'(pv), 0);
        chk("reset_press_ms", int'(press_ms), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (3) step();

        press(c0);
        chk("short_busy", int'(busy), 1);
        wait_to(c0 + 12);
        release_btn();
        push(c0 + 32, SH);
        wait_to(c0 + 40);
        chk("short_press_ms", int'(press_ms), 3);
        chk("short_idle", int'(busy), 0);

        press(c0);
        wait_to(c0 + 12);
        release_btn();
        wait_to(c0 + 20);
        press(c2);
        wait_to(c2 + 8);
        release_btn();
        push(c2 + 8, DB);
        repeat (30) step();
        chk("double_press_ms", int'(press_ms), 2);

        press(c0);
        push(c0 + 40, LG);
        push(c0 + 52, RP);
        push(c0 + 64, RP);
        push(c0 + 76, RP);
        wait_to(c0 + 60);
        chk("long_hold_press_ms", int'(press_ms), 2);
        wait_to(c0 + 80);
        release_btn();
        repeat (30) step();
        chk("long_press_ms", int'(press_ms), 20);
        chk("long_idle", int'(busy), 0);

        press(c0);
        wait_to(c0 + 12);
        release_btn();
        wait_to(c0 + 20);
        press(c2);
        push(c2 + 40, SH | LG);
        wait_to(c2 + 48);
        release_btn();
        repeat (30) step();
        chk("second_long_press_ms", int'(press_ms), 12);

        press(c0);
        step();
        pb_state = 1'b1;
        step();
        step();
        chk("missed_release_idle", int'(busy), 0);
        chk("missed_release_press_ms", int'(press_ms), 12);
        repeat (40) step();

        pb_down = 1'b1;
        pb_up = 1'b1;
        pb_state = 1'b0;
        step();
        pb_down = 1'b0;
        pb_up = 1'b0;
        step();
        chk("down_up_pressed", int'(busy), 1);
        pb_state = 1'b1;
        step();
        step();
        chk("down_up_abort_idle", int'(busy), 0);
        repeat (40) step();
        chk("down_up_press_ms", int'(press_ms), 12);

        press(c0);
        push(c0 + 40, LG);
        wait_to(c0 + 45);
        chk("pre_reset_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pulses", int'(pv), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_press_ms", int'(press_ms), 0);
        pb_state = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        press(c0);
        wait_to(c0 + 12);
        release_btn();
        push(c0 + 32, SH);
        wait_to(c0 + 40);
        chk("post_reset_press_ms", int'(press_ms), 3);
        chk("post_reset_idle", int'(busy), 0);

        repeat (10) step();
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
